// File: rtl/tile_job_scheduler.sv
// Tile-ordered job issuer: walks the screen tile by tile, emitting one background job
// and one job per visible sprite per tile over a valid/ready handshake.
module tile_job_scheduler #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int TILE        = 16,
  parameter int MAX_SPRITES = 32,
  localparam int SIDX_W     = $clog2(MAX_SPRITES),
  localparam int TX_W       = $clog2(SCREEN_W / TILE),
  localparam int TY_W       = $clog2(SCREEN_H / TILE),
  localparam int OFF_W      = $clog2(TILE) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_cr_we,
  input  logic [3:0]        i_cr_addr,
  input  logic [7:0]        i_cr_value,
  output logic [SIDX_W-1:0] o_sprite_idx,
  input  logic [63:0]       i_sprite_struct,
  output logic [TX_W-1:0]   o_tilemap_x_idx,
  output logic [TY_W-1:0]   o_tilemap_y_idx,
  input  logic [7:0]        i_tilemap_texture_idx,
  output logic              o_job_valid,
  input  logic              i_job_ready,
  output logic [7:0]        o_job_texture,
  output logic [7:0]        o_job_z,
  output logic [OFF_W-1:0]  o_job_start_x,
  output logic [OFF_W-1:0]  o_job_start_y,
  output logic [TX_W-1:0]   o_job_tile_x,
  output logic [TY_W-1:0]   o_job_tile_y,
  output logic              o_tile_done,
  output logic              o_frame_done,
  output logic [7:0]        o_frame_cnt,
  output logic              o_busy
);

  localparam int TILES_X = SCREEN_W / TILE;
  localparam int TILES_Y = SCREEN_H / TILE;
  localparam int TILE_LG = $clog2(TILE);
  localparam logic [TX_W-1:0]  TX_LAST = TX_W'(TILES_X - 1);
  localparam logic [TY_W-1:0]  TY_LAST = TY_W'(TILES_Y - 1);
  localparam logic [15:0]      TILE16  = 16'(TILE);
  localparam logic [OFF_W-1:0] BG_OFF  = OFF_W'(TILE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic              enable;
  logic              continuous;
  logic [SIDX_W-1:0] sprite_cnt;
  logic [TX_W-1:0]   tile_x;
  logic [TY_W-1:0]   tile_y;
  logic [SIDX_W-1:0] idx;

  logic [15:0] spr_x, spr_y, px_x, px_y;
  logic [7:0]  spr_tex, spr_z;
  logic        spr_vis, eval, tile_end, row_end, frame_end, start_wr;
  logic        unused_bits;

  // Offset of a sprite edge relative to the tile origin, biased by one tile so a
  // sprite overlapping from the left/top still yields a positive value.
  function automatic logic [OFF_W-1:0] tile_offset(input logic [15:0] coord,
                                                   input logic [15:0] tile_px);
    logic [15:0] diff;
    diff = coord + TILE16 - tile_px;
    return diff[OFF_W-1:0];
  endfunction

  function automatic logic in_span(input logic [15:0] coord, input logic [15:0] tile_px,
                                   input logic first);
    return (first || (coord > (tile_px - TILE16))) && (coord < (tile_px + TILE16));
  endfunction

  assign spr_x   = i_sprite_struct[15:0];
  assign spr_y   = i_sprite_struct[31:16];
  assign spr_tex = i_sprite_struct[39:32];
  assign spr_z   = i_sprite_struct[47:40];
  assign px_x    = 16'(tile_x) << TILE_LG;
  assign px_y    = 16'(tile_y) << TILE_LG;

  assign spr_vis   = (spr_z != 8'd0) && in_span(spr_x, px_x, tile_x == '0)
                                     && in_span(spr_y, px_y, tile_y == '0);
  assign eval      = (state == RUN) && enable && (!o_job_valid || i_job_ready);
  assign tile_end  = idx >= sprite_cnt;
  assign row_end   = tile_x == TX_LAST;
  assign frame_end = row_end && (tile_y == TY_LAST);
  assign start_wr  = i_cr_we && (i_cr_addr == 4'h8) && i_cr_value[0];

  assign o_sprite_idx    = idx;
  assign o_tilemap_x_idx = tile_x;
  assign o_tilemap_y_idx = tile_y;
  assign o_busy          = state == RUN;
  assign unused_bits     = ^{i_sprite_struct[63:48], i_cr_value};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable     <= 1'b1;
      continuous <= 1'b1;
      sprite_cnt <= '0;
    end else if (i_cr_we) begin
      case (i_cr_addr)
        4'h0: begin
          enable     <= i_cr_value[0];
          continuous <= i_cr_value[1];
        end
        4'h4:    sprite_cnt <= i_cr_value[SIDX_W-1:0];
        default: ;
      endcase
    end
  end

  // Evaluation stage: one cursor step per cycle whenever the output slot is free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      tile_x        <= '0;
      tile_y        <= '0;
      idx           <= '0;
      o_job_valid   <= 1'b0;
      o_job_texture <= '0;
      o_job_z       <= '0;
      o_job_start_x <= '0;
      o_job_start_y <= '0;
      o_job_tile_x  <= '0;
      o_job_tile_y  <= '0;
      o_tile_done   <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_cnt   <= '0;
    end else begin
      o_tile_done  <= 1'b0;
      o_frame_done <= 1'b0;

      if (state == IDLE && enable && (continuous || start_wr))
        state <= RUN;

      if (eval) begin
        if (idx == '0) begin
          o_job_valid   <= 1'b1;
          o_job_texture <= i_tilemap_texture_idx;
          o_job_z       <= 8'd0;
          o_job_start_x <= BG_OFF;
          o_job_start_y <= BG_OFF;
          o_job_tile_x  <= tile_x;
          o_job_tile_y  <= tile_y;
        end else if (spr_vis) begin
          o_job_valid   <= 1'b1;
          o_job_texture <= spr_tex;
          o_job_z       <= spr_z;
          o_job_start_x <= tile_offset(spr_x, px_x);
          o_job_start_y <= tile_offset(spr_y, px_y);
          o_job_tile_x  <= tile_x;
          o_job_tile_y  <= tile_y;
        end else begin
          o_job_valid <= 1'b0;
        end

        // A shrunken SPRITE_CNT below idx still ends the tile here.
        if (tile_end) begin
          idx         <= '0;
          o_tile_done <= 1'b1;
          if (row_end) begin
            tile_x <= '0;
            if (frame_end) begin
              tile_y       <= '0;
              o_frame_done <= 1'b1;
              o_frame_cnt  <= o_frame_cnt + 8'd1;
              if (!continuous)
                state <= IDLE;
            end else begin
              tile_y <= tile_y + TY_W'(1);
            end
          end else begin
            tile_x <= tile_x + TX_W'(1);
          end
        end else begin
          idx <= idx + SIDX_W'(1);
        end
      end else if (o_job_valid && i_job_ready) begin
        o_job_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tile_job_scheduler.sv
// Directed bench for tile_job_scheduler: raster frame, sprite vectors with stall and
// enable gaps, SPRITE_CNT shrink, mid-frame reset and single-frame mode.
module tb_tile_job_scheduler;
  localparam int TX_W = 6, TY_W = 5, SIDX_W = 5, OFF_W = 5;
  localparam int TX_N = 40, TY_N = 30, NT = TX_N * TY_N;

  logic              clk, reset_n, i_cr_we, i_job_ready;
  logic [3:0]        i_cr_addr;
  logic [7:0]        i_cr_value, i_tilemap_texture_idx;
  logic [SIDX_W-1:0] o_sprite_idx;
  logic [63:0]       i_sprite_struct;
  logic [TX_W-1:0]   o_tilemap_x_idx, o_job_tile_x;
  logic [TY_W-1:0]   o_tilemap_y_idx, o_job_tile_y;
  logic              o_job_valid, o_tile_done, o_frame_done, o_busy;
  logic [7:0]        o_job_texture, o_job_z, o_frame_cnt;
  logic [OFF_W-1:0]  o_job_start_x, o_job_start_y;

  tile_job_scheduler dut (
    .clk(clk), .reset_n(reset_n), .i_cr_we(i_cr_we), .i_cr_addr(i_cr_addr),
    .i_cr_value(i_cr_value), .o_sprite_idx(o_sprite_idx), .i_sprite_struct(i_sprite_struct),
    .o_tilemap_x_idx(o_tilemap_x_idx), .o_tilemap_y_idx(o_tilemap_y_idx),
    .i_tilemap_texture_idx(i_tilemap_texture_idx), .o_job_valid(o_job_valid),
    .i_job_ready(i_job_ready), .o_job_texture(o_job_texture), .o_job_z(o_job_z),
    .o_job_start_x(o_job_start_x), .o_job_start_y(o_job_start_y),
    .o_job_tile_x(o_job_tile_x), .o_job_tile_y(o_job_tile_y), .o_tile_done(o_tile_done),
    .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt), .o_busy(o_busy)
  );

  typedef struct packed {
    logic [TX_W-1:0]  tx;
    logic [TY_W-1:0]  ty;
    logic [7:0]       tex;
    logic [7:0]       z;
    logic [OFF_W-1:0] sx;
    logic [OFF_W-1:0] sy;
  } job_t;

  typedef struct {
    int   stall;
    int   dis;
    job_t exp;
  } vec_t;

  logic [63:0] spr [32];
  job_t        jq[$];
  int          n_tile_done = 0, n_frame_done = 0, fd_tiles = 0;
  logic        fd_valid = 1'b0;
  logic [TX_W-1:0] fd_tx = '0;
  logic [TY_W-1:0] fd_ty = '0;
  int          checks = 0, passed = 0;

  function automatic logic [7:0] tmap(input logic [TX_W-1:0] x, input logic [TY_W-1:0] y);
    return {2'b0, x} + {3'b0, y} * 8'd40;
  endfunction

  function automatic job_t mk(input logic [TX_W-1:0] tx, input logic [TY_W-1:0] ty,
                              input logic [7:0] tex, input logic [7:0] z,
                              input logic [OFF_W-1:0] sx, input logic [OFF_W-1:0] sy);
    job_t j;
    j.tx = tx; j.ty = ty; j.tex = tex; j.z = z; j.sx = sx; j.sy = sy;
    return j;
  endfunction

  function automatic job_t cur_job();
    return mk(o_job_tile_x, o_job_tile_y, o_job_texture, o_job_z, o_job_start_x, o_job_start_y);
  endfunction

  always_comb i_sprite_struct = spr[o_sprite_idx];
  always_comb i_tilemap_texture_idx = tmap(o_tilemap_x_idx, o_tilemap_y_idx);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfer and pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (o_job_valid && i_job_ready) jq.push_back(cur_job());
      if (o_tile_done) n_tile_done++;
      if (o_frame_done) begin
        n_frame_done++;
        fd_tiles = n_tile_done;
        fd_valid = o_job_valid;
        fd_tx    = o_job_tile_x;
        fd_ty    = o_job_tile_y;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cr_write(input logic [3:0] a, input logic [7:0] v);
    i_cr_we = 1'b1; i_cr_addr = a; i_cr_value = v;
    tick();
    i_cr_we = 1'b0;
  endtask

  task automatic release_with(input logic [3:0] a, input logic [7:0] v);
    reset_n = 1'b1;
    cr_write(a, v);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!o_job_valid && n < 50) begin tick(); n++; end
    check(name, o_job_valid, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (o_busy && n < 3000) begin tick(); n++; end
    check(name, o_busy, 1'b0);
  endtask

  vec_t vecs[6];
  job_t snap;
  logic [15:0] cur_snap;
  int   errs, jb, fb, tdb, n;

  initial begin
    reset_n = 1'b0; i_cr_we = 1'b0; i_cr_addr = '0; i_cr_value = '0; i_job_ready = 1'b0;
    for (int i = 0; i < 32; i++) spr[i] = '0;
    repeat (2) tick();

    check("rst_valid", o_job_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_frame_cnt", o_frame_cnt, 8'd0);
    check("rst_pulses", {o_tile_done, o_frame_done}, 2'b00);
    check("rst_job", cur_job(), 64'd0);
    check("rst_cursor", {o_tilemap_x_idx, o_tilemap_y_idx, o_sprite_idx}, 64'd0);

    // Full background frame in continuous mode, SPRITE_CNT = 0.
    i_job_ready = 1'b1;
    reset_n = 1'b1;
    tick();
    check("busy_after_release", o_busy, 1'b1);
    n = 0;
    while (n_frame_done < 1 && n < 3000) begin tick(); n++; end
    repeat (5) tick();
    check("frame1_pulses", n_frame_done, 1);
    check("frame1_cnt", o_frame_cnt, 8'd1);
    check("frame1_tiles_at_done", fd_tiles, NT);
    check("frame1_last_job", {fd_valid, fd_tx, fd_ty}, {1'b1, 6'd39, 5'd29});
    check("frame1_jobs_seen", jq.size() > NT, 1'b1);
    errs = 0;
    for (int k = 0; k < NT; k++)
      if (jq[k] !== mk(6'(k % TX_N), 5'(k / TX_N), tmap(6'(k % TX_N), 5'(k / TX_N)),
                       8'd0, 5'd16, 5'd16)) errs++;
    check("frame1_bg_jobs", errs, 0);
    check("frame2_first_tile", {jq[NT].tx, jq[NT].ty}, 0);

    // Asynchronous reset in the middle of frame 2.
    repeat (100) tick();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_valid", o_job_valid, 1'b0);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_frame_cnt", o_frame_cnt, 8'd0);
    check("midrst_cursor", {o_tilemap_x_idx, o_tilemap_y_idx, o_sprite_idx}, 64'd0);
    check("midrst_job", cur_job(), 64'd0);

    // Sprite vectors: sprite1 at (12,4) z=5 tex 77, sprite2 z=0 (always culled).
    spr[1] = {16'h0, 8'd5, 8'd77, 16'd4, 16'd12};
    spr[2] = {16'h0, 8'd0, 8'd88, 16'd20, 16'd20};
    i_job_ready = 1'b0;
    vecs[0] = '{stall: 0, dis: 0,  exp: mk(6'd0, 5'd0, tmap(6'd0, 5'd0), 8'd0, 5'd16, 5'd16)};
    vecs[1] = '{stall: 5, dis: 0,  exp: mk(6'd0, 5'd0, 8'd77, 8'd5, 5'd28, 5'd20)};
    vecs[2] = '{stall: 0, dis: 10, exp: mk(6'd1, 5'd0, tmap(6'd1, 5'd0), 8'd0, 5'd16, 5'd16)};
    vecs[3] = '{stall: 0, dis: 0,  exp: mk(6'd1, 5'd0, 8'd77, 8'd5, 5'd12, 5'd20)};
    vecs[4] = '{stall: 0, dis: 0,  exp: mk(6'd2, 5'd0, tmap(6'd2, 5'd0), 8'd0, 5'd16, 5'd16)};
    vecs[5] = '{stall: 0, dis: 0,  exp: mk(6'd3, 5'd0, tmap(6'd3, 5'd0), 8'd0, 5'd16, 5'd16)};
    repeat (2) tick();
    tdb = n_tile_done;
    release_with(4'h4, 8'd2);
    for (int i = 0; i < 6; i++) begin
      wait_valid($sformatf("vec%0d_valid", i));
      check($sformatf("vec%0d_job", i), cur_job(), vecs[i].exp);
      if (vecs[i].stall > 0) begin
        snap = cur_job();
        cur_snap = {o_tilemap_x_idx, o_tilemap_y_idx, o_sprite_idx};
        repeat (vecs[i].stall) tick();
        check($sformatf("vec%0d_stall_job", i), cur_job(), snap);
        check($sformatf("vec%0d_stall_valid", i), o_job_valid, 1'b1);
        check($sformatf("vec%0d_stall_cursor", i),
              {o_tilemap_x_idx, o_tilemap_y_idx, o_sprite_idx}, cur_snap);
      end
      if (vecs[i].dis > 0) begin
        cr_write(4'h0, 8'h2);
        cur_snap = {o_tilemap_x_idx, o_tilemap_y_idx, o_sprite_idx};
        i_job_ready = 1'b1;
        repeat (vecs[i].dis) tick();
        i_job_ready = 1'b0;
        check($sformatf("vec%0d_dis_valid", i), o_job_valid, 1'b0);
        check($sformatf("vec%0d_dis_cursor", i),
              {o_tilemap_x_idx, o_tilemap_y_idx, o_sprite_idx}, cur_snap);
        cr_write(4'h0, 8'h3);
      end else begin
        i_job_ready = 1'b1;
        tick();
        i_job_ready = 1'b0;
      end
    end
    check("vec_tiles_done", n_tile_done - tdb, 3);

    // SPRITE_CNT shrinks from 5 to 1 while sprite 2's job is pending (idx = 3).
    reset_n = 1'b0;
    for (int k = 1; k <= 5; k++) spr[k] = {16'h0, 8'd1, 8'(10 + k), 16'd0, 16'd0};
    repeat (2) tick();
    release_with(4'h4, 8'd5);
    for (int k = 0; k < 2; k++) begin
      wait_valid($sformatf("shr_job%0d_valid", k));
      i_job_ready = 1'b1;
      tick();
      i_job_ready = 1'b0;
    end
    wait_valid("shr_s2_valid");
    check("shr_s2_tex", o_job_texture, 8'd12);
    check("shr_idx3", o_sprite_idx, 5'd3);
    cr_write(4'h4, 8'd1);
    i_job_ready = 1'b1;
    tick();
    i_job_ready = 1'b0;
    check("shr_tile_done", o_tile_done, 1'b1);
    check("shr_last_job", cur_job(), mk(6'd0, 5'd0, 8'd13, 8'd1, 5'd16, 5'd16));
    check("shr_cursor", {o_tilemap_x_idx, o_sprite_idx}, {6'd1, 5'd0});
    i_job_ready = 1'b1;
    tick();
    i_job_ready = 1'b0;
    check("shr_next_bg", {o_job_valid, o_job_tile_x, o_job_texture}, {1'b1, 6'd1, 8'd1});

    // Single-frame mode.
    reset_n = 1'b0;
    for (int k = 1; k <= 5; k++) spr[k] = '0;
    i_job_ready = 1'b1;
    repeat (2) tick();
    jb = jq.size();
    fb = n_frame_done;
    release_with(4'h0, 8'h1);
    wait_idle("sf_idle1");
    repeat (20) tick();
    check("sf_jobs1", jq.size() - jb, NT);
    check("sf_frames1", n_frame_done - fb, 1);
    check("sf_cnt1", o_frame_cnt, 8'd1);
    check("sf_still_idle", o_busy, 1'b0);
    cr_write(4'h8, 8'h1);
    check("sf_start_busy", o_busy, 1'b1);
    repeat (50) tick();
    cr_write(4'h8, 8'h1);
    wait_idle("sf_idle2");
    repeat (20) tick();
    check("sf_jobs2", jq.size() - jb, 2 * NT);
    check("sf_frames2", n_frame_done - fb, 2);
    check("sf_cnt2", o_frame_cnt, 8'd2);
    check("sf_idle_end", o_busy, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
